alu_mpa_seq: RTL and testbench

//  Multi-precision add/subtract sequencer for the 32-bit ALU (op: add=0, addc=1, sub=2, subc=3).

---
 rtl/alu_mpa_seq.sv | 149 ++++++++++++++
 tb/tb_alu_mpa_seq.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mpa_seq.sv
// Multi-precision add/subtract sequencer: streams LS-first word pairs through an external
// combinational ALU with a registered carry chain and a 1-entry result buffer.
module alu_mpa_seq #(
  parameter int W  = 32,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          sub,
  input  logic [CW-1:0] len,
  output logic          busy,
  output logic          done,
  output logic          carry_out,
  output logic          ovfl_out,
  input  logic [W-1:0]  a_word,
  input  logic [W-1:0]  b_word,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [W-1:0]  res_word,
  output logic          res_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  alu_a,
  output logic [W-1:0]  alu_b,
  output logic [1:0]    alu_op,
  output logic          alu_cin,
  input  logic [W-1:0]  alu_result,
  input  logic          alu_cout
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

  state_t        state_q, state_d;
  logic          sub_q, sub_d;
  logic [CW-1:0] len_q, len_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          carry_q, carry_d;
  logic          carry_out_q, carry_out_d;
  logic          ovfl_out_q, ovfl_out_d;
  logic          out_valid_q, out_valid_d;
  logic [W-1:0]  res_word_q, res_word_d;
  logic          res_last_q, res_last_d;
  logic          done_q, done_d;

  logic [W-1:0]  b_eff;
  logic          accept;
  logic          out_hs;
  logic          last_word;

  // Subtraction is A + ~B + carry with the carry seeded to 1, so the ALU always runs addc.
  always_comb begin
    b_eff     = sub_q ? ~b_word : b_word;
    alu_a     = a_word;
    alu_b     = b_eff;
    alu_op    = (state_q == IDLE) ? 2'd0 : 2'd1;
    alu_cin   = (state_q == IDLE) ? 1'b0 : carry_q;
    in_ready  = (state_q == RUN) && (!out_valid_q || out_ready);
    accept    = in_valid && in_ready;
    out_hs    = out_valid_q && out_ready;
    last_word = (cnt_q == len_q);
  end

  always_comb begin
    state_d     = state_q;
    sub_d       = sub_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    carry_out_d = carry_out_q;
    ovfl_out_d  = ovfl_out_q;
    res_word_d  = res_word_q;
    res_last_d  = res_last_q;
    done_d      = 1'b0;
    out_valid_d = accept ? 1'b1 : (out_hs ? 1'b0 : out_valid_q);
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = RUN;
          sub_d       = sub;
          len_d       = len;
          cnt_d       = '0;
          carry_d     = sub;
          carry_out_d = 1'b0;
          ovfl_out_d  = 1'b0;
        end
      end
      RUN: begin
        if (accept) begin
          res_word_d = alu_result;
          res_last_d = last_word;
          carry_d    = alu_cout;
          if (last_word) begin
            carry_out_d = alu_cout;
            ovfl_out_d  = (a_word[W-1] == b_eff[W-1]) && (alu_result[W-1] != a_word[W-1]);
            state_d     = DRAIN;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      DRAIN: begin
        // Only the MS word can be buffered here, so its handshake ends the command.
        if (out_hs && res_last_q) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sub_q       <= 1'b0;
      len_q       <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      carry_out_q <= 1'b0;
      ovfl_out_q  <= 1'b0;
      out_valid_q <= 1'b0;
      res_word_q  <= '0;
      res_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sub_q       <= sub_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      carry_out_q <= carry_out_d;
      ovfl_out_q  <= ovfl_out_d;
      out_valid_q <= out_valid_d;
      res_word_q  <= res_word_d;
      res_last_q  <= res_last_d;
      done_q      <= done_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign carry_out = carry_out_q;
  assign ovfl_out  = ovfl_out_q;
  assign out_valid = out_valid_q;
  assign res_word  = res_word_q;
  assign res_last  = res_last_q;

endmodule

// File: tb/tb_alu_mpa_seq.sv
// Scoreboard bench for alu_mpa_seq: a wide-integer reference model predicts every result word
// and the final carry/overflow; a monitor compares them as the DUT emits them.
module tb_alu_mpa_seq;
  localparam int W  = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          sub;
  logic [CW-1:0] len;
  logic          busy, done, carry_out, ovfl_out;
  logic [W-1:0]  a_word, b_word;
  logic          in_valid, in_ready;
  logic [W-1:0]  res_word;
  logic          res_last, out_valid, out_ready;
  logic [W-1:0]  alu_a, alu_b, alu_result;
  logic [1:0]    alu_op;
  logic          alu_cin, alu_cout;

  always #5 clk = ~clk;

  alu_mpa_seq #(.W(W), .CW(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .len(len),
    .busy(busy), .done(done), .carry_out(carry_out), .ovfl_out(ovfl_out),
    .a_word(a_word), .b_word(b_word), .in_valid(in_valid), .in_ready(in_ready),
    .res_word(res_word), .res_last(res_last), .out_valid(out_valid), .out_ready(out_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_cin(alu_cin),
    .alu_result(alu_result), .alu_cout(alu_cout)
  );

  // Combinational 32-bit ALU model: add, addc, sub, subc.
  logic [W:0] alu_sum;
  always_comb begin
    case (alu_op)
      2'd0:    alu_sum = {1'b0, alu_a} + {1'b0, alu_b};
      2'd1:    alu_sum = {1'b0, alu_a} + {1'b0, alu_b} + {{W{1'b0}}, alu_cin};
      2'd2:    alu_sum = {1'b0, alu_a} + {1'b0, ~alu_b} + {{W{1'b0}}, 1'b1};
      default: alu_sum = {1'b0, alu_a} + {1'b0, ~alu_b} + {{W{1'b0}}, alu_cin};
    endcase
    alu_result = alu_sum[W-1:0];
    alu_cout   = alu_sum[W];
  end

  typedef struct packed { logic [W-1:0] w; logic last; } res_t;
  typedef struct packed { logic c; logic o; } fin_t;
  res_t res_q[$];
  fin_t fin_q[$];

  int checks = 0;
  int errors = 0;
  int rdy_mode = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference: treat the operands as N-bit unsigned/signed integers.
  task automatic push_exp(input logic s, input int n, input logic [511:0] a, input logic [511:0] b);
    int nb;
    logic [512:0] m, ax, bx, r;
    logic c, o, as, bs, rs;
    res_t e;
    fin_t f;
    nb = 32 * n;
    m  = (513'd1 << nb) - 513'd1;
    ax = {1'b0, a} & m;
    bx = {1'b0, b} & m;
    r  = s ? (ax - bx) : (ax + bx);
    c  = s ? (ax >= bx) : r[nb];
    as = ax[nb-1];
    bs = bx[nb-1];
    rs = r[nb-1];
    o  = s ? ((as != bs) && (rs != as)) : ((as == bs) && (rs != as));
    for (int i = 0; i < n; i++) begin
      e.w = r[32*i +: 32];
      e.last = (i == n - 1);
      res_q.push_back(e);
    end
    f.c = c;
    f.o = o;
    fin_q.push_back(f);
    $display("cmd %s n=%0d carry=%0d ovfl=%0d", s ? "sub" : "add", n, c, o);
  endtask

  task automatic do_start(input logic s, input int n);
    int t = 0;
    while (t < 300) begin
      @(negedge clk);
      if (!busy) break;
      t++;
    end
    if (t >= 300) chk("start_wait_timeout", 64'(1), 64'(0));
    @(posedge clk); #1;
    start = 1'b1;
    sub   = s;
    len   = CW'(n - 1);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic feed(input logic [511:0] a, input logic [511:0] b, input int n,
                      input bit gaps, input bit mid_start, input logic s);
    int t;
    for (int i = 0; i < n; i++) begin
      if (gaps && ($urandom_range(0, 2) == 0)) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      a_word   = a[32*i +: 32];
      b_word   = b[32*i +: 32];
      in_valid = 1'b1;
      if (mid_start && i == 1) begin
        start = 1'b1;
        sub   = ~s;
        len   = CW'($urandom_range(0, 15));
      end
      t = 0;
      while (t < 300) begin
        @(negedge clk);
        if (in_ready) break;
        t++;
        @(posedge clk); #1;
      end
      if (t >= 300) begin
        chk("in_ready_timeout", 64'(1), 64'(0));
        break;
      end
      @(posedge clk); #1;
      start = 1'b0;
    end
    in_valid = 1'b0;
    a_word   = $urandom;
    b_word   = $urandom;
  endtask

  task automatic wait_done();
    bit got = 0;
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      if (done) begin
        got = 1;
        break;
      end
    end
    chk("done_seen", 64'(got), 64'(1));
    if (got) chk("busy_after_done", 64'(busy), 64'(0));
    @(posedge clk); #1;
  endtask

  task automatic run_cmd(input logic s, input int n, input logic [511:0] a, input logic [511:0] b,
                         input int mode, input bit gaps, input bit mid_start);
    rdy_mode = mode;
    push_exp(s, n, a, b);
    do_start(s, n);
    feed(a, b, n, gaps, mid_start, s);
    wait_done();
  endtask

  // Sink readiness: always, random, or a 3-cycle stall mid-stream.
  initial begin
    int c;
    c = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (rdy_mode == 2) c++;
      else c = 0;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = !(c >= 6 && c < 9);
      endcase
    end
  end

  // Monitor: pops the scoreboard on every output handshake and on every done pulse.
  initial begin
    bit   held_v = 0;
    bit   prev_last_hs = 0;
    res_t held;
    res_t e;
    fin_t f;
    forever begin
      @(negedge clk);
      if (rst) begin
        held_v = 0;
        prev_last_hs = 0;
      end else begin
        if (held_v && out_valid) begin
          chk("res_word_held", 64'(res_word), 64'(held.w));
          chk("res_last_held", 64'(res_last), 64'(held.last));
        end
        if (out_valid && !out_ready) chk("in_ready_backpressure", 64'(in_ready), 64'(0));
        if (out_valid && out_ready) begin
          if (res_q.size() == 0) begin
            chk("res_unexpected", 64'(1), 64'(0));
          end else begin
            e = res_q.pop_front();
            chk("res_word", 64'(res_word), 64'(e.w));
            chk("res_last", 64'(res_last), 64'(e.last));
            $display("out word=%08h last=%0d exp=%08h", res_word, res_last, e.w);
          end
        end
        if (done) begin
          chk("done_after_last_hs", 64'(prev_last_hs), 64'(1));
          if (fin_q.size() == 0) begin
            chk("done_unexpected", 64'(1), 64'(0));
          end else begin
            f = fin_q.pop_front();
            chk("carry_out", 64'(carry_out), 64'(f.c));
            chk("ovfl_out", 64'(ovfl_out), 64'(f.o));
          end
        end
        held_v = out_valid && !out_ready;
        held.w = res_word;
        held.last = res_last;
        prev_last_hs = out_valid && out_ready && res_last;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [511:0] a, b;
    int n;
    logic s;
    rst = 1'b1; start = 1'b0; sub = 1'b0; len = '0;
    a_word = '0; b_word = '0; in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_carry_out", 64'(carry_out), 64'(0));
    chk("rst_ovfl_out", 64'(ovfl_out), 64'(0));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_res_word", 64'(res_word), 64'(0));
    chk("rst_res_last", 64'(res_last), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    chk("idle_alu_op", 64'(alu_op), 64'(0));
    chk("idle_alu_cin", 64'(alu_cin), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;

    run_cmd(1'b0, 2, 512'h1_FFFFFFFF, 512'h0_00000001, 0, 0, 0);
    run_cmd(1'b1, 1, 512'h5, 512'h7, 0, 0, 0);
    run_cmd(1'b1, 1, 512'h5, 512'h0, 0, 0, 0);
    run_cmd(1'b0, 1, 512'h7FFFFFFF, 512'h1, 0, 0, 0);
    run_cmd(1'b1, 1, 512'h80000000, 512'h1, 0, 0, 0);

    // 16-word add with a sink stall mid-stream; all-ones A makes the carry ripple.
    for (int i = 0; i < 16; i++) begin
      a[32*i +: 32] = (i % 3 == 0) ? $urandom : 32'hFFFFFFFF;
      b[32*i +: 32] = $urandom;
    end
    run_cmd(1'b0, 16, a, b, 2, 0, 0);

    // Reset after 2 of 4 words.
    rdy_mode = 0;
    for (int i = 0; i < 16; i++) begin
      a[32*i +: 32] = $urandom;
      b[32*i +: 32] = $urandom;
    end
    push_exp(1'b0, 4, a, b);
    do_start(1'b0, 4);
    feed(a, b, 2, 0, 0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_out_valid", 64'(out_valid), 64'(0));
    res_q.delete();
    fin_q.delete();
    $display("reset mid-command, scoreboard flushed");
    repeat (6) @(posedge clk);
    #1;
    run_cmd(1'b1, 1, 512'h12345678, 512'h00000078, 0, 0, 0);

    // Start pulsed while running must be ignored.
    for (int i = 0; i < 16; i++) begin
      a[32*i +: 32] = $urandom;
      b[32*i +: 32] = $urandom;
    end
    run_cmd(1'b0, 5, a, b, 0, 0, 1);
    run_cmd(1'b1, 3, a, b, 1, 0, 1);

    for (int k = 0; k < 30; k++) begin
      n = $urandom_range(1, 16);
      s = $urandom_range(0, 1) == 1;
      for (int i = 0; i < 16; i++) begin
        case ($urandom_range(0, 3))
          0:       a[32*i +: 32] = 32'hFFFFFFFF;
          1:       a[32*i +: 32] = 32'h0;
          default: a[32*i +: 32] = $urandom;
        endcase
        case ($urandom_range(0, 3))
          0:       b[32*i +: 32] = 32'h0;
          1:       b[32*i +: 32] = 32'h80000000;
          default: b[32*i +: 32] = $urandom;
        endcase
      end
      run_cmd(s, n, a, b, 1, 1, 0);
    end

    repeat (5) @(posedge clk);
    chk("scoreboard_empty", 64'(res_q.size() + fin_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
